control_pipe: RTL and testbench

Parametrised pipelined control unit for the five-stage RISC-V core. It decodes the instruction held in IF/ID and registers the resulting control bundle into the ID/EX stage. It adds three things a plain combinational decoder does not have: load-use hazard bubbling, flush squashing, and a multi-cycle MUL stall FSM. It drives the stall line consumed by the PC and IF/ID registers.

---
 rtl/control_pipe.sv | 196 +++++++++++++++++++
 tb/tb_control_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Pipelined ID-stage control unit: decodes IF/ID into a registered ID/EX control bundle,
// with load-use bubbling, flush squashing and a multi-cycle MUL occupancy FSM.
module control_pipe #(
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned MUL_CYCLES = 3,
  parameter bit          ENABLE_MUL = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        instr_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic               ex_memread_i,
  input  logic [4:0]         ex_rd_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_regwrite_o,
  output logic               ex_memtoreg_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               ex_branch_o,
  output logic               ex_mul_busy_o,
  output logic               illegal_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic       alusrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
  } ctrl_t;

  localparam logic [3:0] CntInit = 4'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ex_q, ex_d, dec;
  logic       illegal_q, illegal_d;
  logic       dec_illegal, dec_mul, use_rs1, use_rs2;
  logic       hazard, accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign rs1          = instr_i[19:15];
  assign rs2          = instr_i[24:20];
  assign unused_instr = ^{instr_i[31], instr_i[29:26], instr_i[11:7]};

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.valid    = 1'b1;
        dec.regwrite = 1'b1;
        if (instr_i[25]) begin
          if (ENABLE_MUL) begin
            dec.op  = 3'd3;
            dec_mul = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (funct3 == 3'b000 && instr_i[30]) begin
          dec.op = 3'd2;
        end else if (funct3 == 3'b101) begin
          dec.op = 3'd5;
        end else if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec_illegal = 1'b1;
        end else begin
          dec.op = funct3;
        end
      end
      7'b0010011: begin
        use_rs1      = 1'b1;
        dec.valid    = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.op       = funct3;
        dec_illegal  = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      7'b0000011: begin
        use_rs1      = 1'b1;
        dec.valid    = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
        dec.memread  = 1'b1;
      end
      7'b0100011: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.valid    = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      7'b1100011: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.valid  = 1'b1;
        dec.branch = 1'b1;
        dec.op     = 3'd2;
      end
      7'b0000000: ;
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings still report their sources for hazard purposes, but issue a bubble.
    if (dec_illegal) begin
      dec     = '0;
      dec_mul = 1'b0;
    end
  end

  assign hazard = valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                  ((use_rs1 & (rs1 == ex_rd_i)) | (use_rs2 & (rs2 == ex_rd_i)));

  assign accept = (state_q == StIdle) & ~flush_i & ~hazard & valid_i;

  always_comb begin
    ex_d      = '0;
    illegal_d = illegal_q | (accept & dec_illegal);
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (state_q == StBusy) begin
      ex_d = ex_q;
    end else if (accept) begin
      ex_d = dec;
    end
    case (state_q)
      StIdle: begin
        if (accept && dec_mul && MUL_CYCLES > 1) begin
          state_d = StBusy;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        // Leaving BUSY still holds ID/EX for one more cycle, giving MUL_CYCLES of occupancy.
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign stall_o = ((state_q == StBusy) & (cnt_q != 4'd0)) |
                   (hazard & (state_q == StIdle) & ~flush_i);

  assign ex_valid_o    = ex_q.valid;
  assign ex_aluop_o    = ALUOP_W'(ex_q.op);
  assign ex_alusrc_o   = ex_q.alusrc;
  assign ex_regwrite_o = ex_q.regwrite;
  assign ex_memtoreg_o = ex_q.memtoreg;
  assign ex_memread_o  = ex_q.memread;
  assign ex_memwrite_o = ex_q.memwrite;
  assign ex_branch_o   = ex_q.branch;
  assign ex_mul_busy_o = (state_q == StBusy);
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: expected ID/EX bundles are queued at drive time and
// compared after the capturing edge.
module tb_control_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        valid_i, flush_i, ex_memread_i;
  logic [4:0]  ex_rd_i;
  logic        stall_o, ex_valid_o, ex_alusrc_o, ex_regwrite_o, ex_memtoreg_o;
  logic        ex_memread_o, ex_memwrite_o, ex_branch_o, ex_mul_busy_o, illegal_o;
  logic [3:0]  ex_aluop_o;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic       alusrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  control_pipe #(.ALUOP_W(4), .MUL_CYCLES(3), .ENABLE_MUL(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .stall_o      (stall_o),
    .ex_valid_o   (ex_valid_o),
    .ex_aluop_o   (ex_aluop_o),
    .ex_alusrc_o  (ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o),
    .ex_memtoreg_o(ex_memtoreg_o),
    .ex_memread_o (ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o),
    .ex_branch_o  (ex_branch_o),
    .ex_mul_busy_o(ex_mul_busy_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] IAdd  = 32'h002081B3;
  localparam logic [31:0] ISub  = 32'h402081B3;
  localparam logic [31:0] ISra  = 32'h4020D1B3;
  localparam logic [31:0] ISrai = 32'h4020D193;
  localparam logic [31:0] ISlt  = 32'h0020A1B3;
  localparam logic [31:0] IMul  = 32'h022081B3;
  localparam logic [31:0] ILw   = 32'h0000A183;
  localparam logic [31:0] ISw   = 32'h0020A023;
  localparam logic [31:0] IBeq  = 32'h00208063;

  localparam exp_t EBub  = '0;
  localparam exp_t EAdd  = '{valid: 1'b1, op: 4'd0, alusrc: 1'b0, regwrite: 1'b1, default: 1'b0};
  localparam exp_t ESub  = '{valid: 1'b1, op: 4'd2, alusrc: 1'b0, regwrite: 1'b1, default: 1'b0};
  localparam exp_t ESra  = '{valid: 1'b1, op: 4'd5, alusrc: 1'b0, regwrite: 1'b1, default: 1'b0};
  localparam exp_t ESrai = '{valid: 1'b1, op: 4'd5, alusrc: 1'b1, regwrite: 1'b1, default: 1'b0};
  localparam exp_t EMul  = '{valid: 1'b1, op: 4'd3, alusrc: 1'b0, regwrite: 1'b1, default: 1'b0};
  localparam exp_t ELw   = '{valid: 1'b1, op: 4'd0, alusrc: 1'b1, regwrite: 1'b1, memtoreg: 1'b1,
                             memread: 1'b1, default: 1'b0};
  localparam exp_t ESw   = '{valid: 1'b1, op: 4'd0, alusrc: 1'b1, memwrite: 1'b1, default: 1'b0};
  localparam exp_t EBeq  = '{valid: 1'b1, op: 4'd2, branch: 1'b1, default: 1'b0};

  function automatic exp_t observed();
    return {ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_regwrite_o, ex_memtoreg_o,
            ex_memread_o, ex_memwrite_o, ex_branch_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: drive inputs, check combinational stall, queue the ID/EX expectation,
  // clock, then compare the registered bundle plus busy/illegal.
  task automatic cyc(input string tag, input logic [31:0] ins, input logic v, input logic fl,
                     input logic mr, input logic [4:0] rd, input exp_t e, input logic st,
                     input logic busy_after, input logic ill_after);
    exp_t want;
    instr_i      = ins;
    valid_i      = v;
    flush_i      = fl;
    ex_memread_i = mr;
    ex_rd_i      = rd;
    #1;
    chk({tag, ".stall"}, 32'(stall_o), 32'(st));
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    want = sb_q.pop_front();
    chk({tag, ".idex"}, 32'(observed()), 32'(want));
    chk({tag, ".busy"}, 32'(ex_mul_busy_o), 32'(busy_after));
    chk({tag, ".illegal"}, 32'(illegal_o), 32'(ill_after));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".idex"}, 32'(observed()), 32'(EBub));
    chk({tag, ".busy"}, 32'(ex_mul_busy_o), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal_o), 32'd0);
    chk({tag, ".stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    rst_i        = 1'b0;
    instr_i      = 32'h0;
    valid_i      = 1'b0;
    flush_i      = 1'b0;
    ex_memread_i = 1'b0;
    ex_rd_i      = 5'd0;
    #3;
    chk_reset_vals("rst0");
    instr_i = IAdd;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_reset_vals("rst_edge");
    rst_i = 1'b1;

    cyc("add",  IAdd,  1'b1, 1'b0, 1'b0, 5'd0, EAdd,  1'b0, 1'b0, 1'b0);
    cyc("sub",  ISub,  1'b1, 1'b0, 1'b0, 5'd0, ESub,  1'b0, 1'b0, 1'b0);
    cyc("sra",  ISra,  1'b1, 1'b0, 1'b0, 5'd0, ESra,  1'b0, 1'b0, 1'b0);
    cyc("srai", ISrai, 1'b1, 1'b0, 1'b0, 5'd0, ESrai, 1'b0, 1'b0, 1'b0);
    cyc("lw",   ILw,   1'b1, 1'b0, 1'b0, 5'd0, ELw,   1'b0, 1'b0, 1'b0);
    cyc("sw",   ISw,   1'b1, 1'b0, 1'b0, 5'd0, ESw,   1'b0, 1'b0, 1'b0);
    cyc("beq",  IBeq,  1'b1, 1'b0, 1'b0, 5'd0, EBeq,  1'b0, 1'b0, 1'b0);
    cyc("novalid", IAdd, 1'b0, 1'b0, 1'b0, 5'd0, EBub, 1'b0, 1'b0, 1'b0);
    cyc("nop0", 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, EBub, 1'b0, 1'b0, 1'b0);

    // Load-use on rs1, then the same with rd=x0 (no hazard), then rs2 match.
    cyc("lu_rs1", IAdd, 1'b1, 1'b0, 1'b1, 5'd1, EBub, 1'b1, 1'b0, 1'b0);
    cyc("lu_x0",  IAdd, 1'b1, 1'b0, 1'b1, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2", ISw,  1'b1, 1'b0, 1'b1, 5'd2, EBub, 1'b1, 1'b0, 1'b0);
    cyc("lu_none", IAdd, 1'b1, 1'b0, 1'b1, 5'd7, EAdd, 1'b0, 1'b0, 1'b0);
    cyc("flush_lu", IAdd, 1'b1, 1'b1, 1'b1, 5'd1, EBub, 1'b0, 1'b0, 1'b0);

    // MUL occupies ID/EX for 3 cycles; flush during BUSY is ignored.
    cyc("mul0",   IMul, 1'b1, 1'b0, 1'b0, 5'd0, EMul, 1'b0, 1'b1, 1'b0);
    cyc("mul1",   IAdd, 1'b1, 1'b1, 1'b0, 5'd0, EMul, 1'b1, 1'b1, 1'b0);
    cyc("mul2",   IAdd, 1'b1, 1'b0, 1'b0, 5'd0, EMul, 1'b1, 1'b0, 1'b0);
    cyc("mul_nx", IAdd, 1'b1, 1'b0, 1'b0, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);

    cyc("slt",     ISlt, 1'b1, 1'b0, 1'b0, 5'd0, EBub, 1'b0, 1'b0, 1'b1);
    cyc("ill_stk", IAdd, 1'b1, 1'b0, 1'b0, 5'd0, EAdd, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    cyc("mulr", IMul, 1'b1, 1'b0, 1'b0, 5'd0, EMul, 1'b0, 1'b1, 1'b1);
    instr_i = IAdd;
    #2;
    rst_i = 1'b0;
    #1;
    chk_reset_vals("rst_busy");
    @(posedge clk_i);
    #1;
    chk_reset_vals("rst_busy_edge");
    rst_i = 1'b1;
    cyc("post_rst", IAdd, 1'b1, 1'b0, 1'b0, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
